// File: rtl/fpu_pkg.sv
// Shared FP adder definitions: operand format and the captured result record.
package fpu_pkg;

  localparam int FP_W      = 64;
  localparam int EXP_W     = 10;
  localparam int MAN_W     = 53;
  localparam int EXP_BIAS  = 511;
  localparam int FPU_TAG_W = 4;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] mant;
  } fp64_t;

  typedef struct packed {
    logic [FP_W-1:0]      res;
    logic [FP_W-1:0]      res2;
    logic [FPU_TAG_W-1:0] tag;
  } fpu_res_t;

endpackage

// File: rtl/fpu_res_fifo.sv
// Show-ahead synchronous FIFO; a written entry becomes readable one cycle after its push.
module fpu_res_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     ready,
  output logic                     valid,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          fresh;
  logic          full;
  logic          do_push;
  logic          do_pop;

  // The newest entry is hidden for one cycle, so an empty FIFO never bypasses.
  assign full    = (count == (AW+1)'(DEPTH));
  assign valid   = (count > {{AW{1'b0}}, fresh});
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = valid & ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      fresh  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      fresh <= do_push;
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) assert (!(push && full));
  end

endmodule

// File: rtl/fpuadd_issue.sv
// Issue/collect wrapper for the fixed-latency FP adder with credit-guarded result FIFO.
module fpuadd_issue
  import fpu_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int DEPTH = 4,
  parameter int TAG_W = FPU_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic             in_rnd,
  input  logic             in_pookm,
  input  logic [TAG_W-1:0] in_tag,
  output logic [63:0]      add_a,
  output logic [63:0]      add_b,
  output logic             add_rnd,
  output logic             add_pookm,
  input  logic [63:0]      add_res,
  input  logic [63:0]      add_res2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_res,
  output logic [63:0]      out_res2,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int INF_W = $clog2(LAT + 2);
  localparam int CRD_W = $clog2(DEPTH + LAT + 2);

  logic             accept;
  logic [LAT:0]     pv_valid;
  logic [TAG_W-1:0] pv_tag [LAT+1];
  logic [INF_W-1:0] inflight;
  logic [CNT_W-1:0] count;
  logic [CRD_W-1:0] credit_used;
  logic             fifo_valid;
  fp64_t            a_q;
  fp64_t            b_q;
  fpu_res_t         push_data;
  fpu_res_t         head;

  // NOTE: the accumulator is defaulted before the loop so no latch is inferred.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= LAT; i++) inflight = inflight + INF_W'(pv_valid[i]);
  end

  // Every op in the pipe already owns a FIFO slot, so a capture can never overflow.
  assign credit_used = CRD_W'(count) + CRD_W'(inflight);
  assign in_ready    = rst & (credit_used < CRD_W'(DEPTH));
  assign accept      = in_valid & in_ready;

  // NOTE: non-blocking assignments keep every stage sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) pv_valid <= '0;
    else      pv_valid <= {pv_valid[LAT-1:0], accept};
  end

  always_ff @(posedge clk) begin
    pv_tag[0] <= in_tag;
    for (int i = 1; i <= LAT; i++) pv_tag[i] <= pv_tag[i-1];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q       <= '0;
      b_q       <= '0;
      add_rnd   <= 1'b0;
      add_pookm <= 1'b0;
    end else begin
      if (accept) begin
        a_q     <= in_a;
        b_q     <= in_b;
        add_rnd <= in_rnd;
      end
      add_pookm <= accept & in_pookm;
    end
  end

  assign add_a = a_q;
  assign add_b = b_q;

  assign push_data = '{res: add_res, res2: add_res2, tag: pv_tag[LAT]};

  fpu_res_fifo #(
    .W     ($bits(fpu_res_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pv_valid[LAT]),
    .push_data (push_data),
    .ready     (out_ready),
    .valid     (fifo_valid),
    .head      (head),
    .count     (count)
  );

  assign out_valid = rst & fifo_valid;
  assign out_res   = head.res;
  assign out_res2  = head.res2;
  assign out_tag   = head.tag;
  assign busy      = rst & ((inflight != '0) | (count != '0));

endmodule

// File: tb/tb_fpuadd_issue.sv
// Scoreboard bench for fpuadd_issue with a LAT=2 adder model (res=A^B, res2=A+B).
module tb_fpuadd_issue;
  import fpu_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_rnd, in_pookm;
  logic [63:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic [63:0] add_a, add_b, add_res, add_res2;
  logic        add_rnd, add_pookm;
  logic        out_valid, out_ready;
  logic [63:0] out_res, out_res2;
  logic [3:0]  out_tag;
  logic        busy;

  always #5 clk = ~clk;

  fpuadd_issue #(.LAT(LAT), .DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_rnd(in_rnd), .in_pookm(in_pookm), .in_tag(in_tag),
    .add_a(add_a), .add_b(add_b), .add_rnd(add_rnd), .add_pookm(add_pookm),
    .add_res(add_res), .add_res2(add_res2),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_res2(out_res2), .out_tag(out_tag), .busy(busy)
  );

  // Adder model: fixed two-cycle delay from add_a/add_b.
  logic [63:0] d_res [LAT];
  logic [63:0] d_res2 [LAT];
  always @(posedge clk) begin
    d_res[0]  <= add_a ^ add_b;
    d_res2[0] <= add_a + add_b;
    for (int i = 1; i < LAT; i++) begin
      d_res[i]  <= d_res[i-1];
      d_res2[i] <= d_res2[i-1];
    end
  end
  assign add_res  = d_res[LAT-1];
  assign add_res2 = d_res2[LAT-1];

  typedef struct {
    logic [63:0] res;
    logic [63:0] res2;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_pop   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: expectations enter on accept, are compared on every pop.
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_pop++;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL stale_result: got tag %0d res %h, expected no result", out_tag, out_res);
        end else begin
          e = sb.pop_front();
          check("out_res", out_res, e.res);
          check("out_res2", out_res2, e.res2);
          check("out_tag", 64'(out_tag), 64'(e.tag));
        end
      end
      if (in_valid && in_ready) sb.push_back('{in_a ^ in_b, in_a + in_b, in_tag});
    end
  end

  function automatic logic [63:0] op_a(input int i);
    return 64'h3FF0_0000_0000_0000 + 64'(i) * 64'h0001_2345_6789_0011;
  endfunction

  function automatic logic [63:0] op_b(input int i);
    return 64'hC010_8000_0000_0000 ^ (64'(i) * 64'h0000_0F0F_0000_1234);
  endfunction

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [3:0] tag,
                      input logic pookm);
    int   n = 0;
    logic acc = 1'b0;
    in_a = a; in_b = b; in_tag = tag; in_rnd = tag[0]; in_pookm = pookm; in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready 0 for 50 cycles, expected accept of tag %0d", tag);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    out_ready = 1'b1;
    while ((busy || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(negedge clk);
    check({name, "_idle"}, 64'(busy), 64'd0);
    check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  lat, acc, p0;
    bit  done;
    rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_rnd = 1'b0; in_pookm = 1'b0;
    in_tag = '0; out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_add_a", add_a, 64'd0);
    check("rst_add_pookm", 64'(add_pookm), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Single op
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(64'h3FE0_0000_0000_0000, 64'h4000_0000_0000_0000, 4'd3, 1'b1);
    in_valid = 1'b0; in_pookm = 1'b0;
    check("single_add_a", add_a, 64'h3FE0_0000_0000_0000);
    check("single_pookm_load", 64'(add_pookm), 64'd1);
    check("single_out_res_formula", 64'h3FE0_0000_0000_0000 ^ 64'h4000_0000_0000_0000,
          64'h7FE0_0000_0000_0000);
    @(posedge clk); #1;
    lat = 1;
    check("single_pookm_clear", 64'(add_pookm), 64'd0);
    check("single_add_a_hold", add_a, 64'h3FE0_0000_0000_0000);
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("single_latency", 64'(lat), 64'd4);
    check("single_out_res", out_res, 64'h7FE0_0000_0000_0000);
    check("single_out_tag", 64'(out_tag), 64'd3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("single_busy_clear", 64'(busy), 64'd0);

    // Back-to-back, in_valid held high
    @(posedge clk); #1;
    p0 = n_pop;
    for (int i = 0; i < 8; i++) send(op_a(i), op_b(i), 4'(i), 1'b0);
    in_valid = 1'b0;
    drain("b2b");
    check("b2b_pops", 64'(n_pop - p0), 64'd8);

    // Back-pressure: credit stops issue at four
    @(posedge clk); #1;
    out_ready = 1'b0;
    acc = 0;
    p0 = n_pop;
    in_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_a = op_a(20 + acc); in_b = op_b(20 + acc); in_tag = 4'(acc);
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_accepts", 64'(acc), 64'd4);
    @(negedge clk);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_head_tag", 64'(out_tag), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_before_pop", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_in_ready_after_pop", 64'(in_ready), 64'd1);
    drain("bp");
    check("bp_pops", 64'(n_pop - p0), 64'd4);

    // Simultaneous push and pop with two entries held
    @(posedge clk); #1;
    out_ready = 1'b0;
    p0 = n_pop;
    for (int i = 0; i < 3; i++) send(op_a(40 + i), op_b(40 + i), 4'(8 + i), 1'b0);
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(negedge clk);
    check("pp_valid", 64'(out_valid), 64'd1);
    check("pp_head_before", 64'(out_tag), 64'd8);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("pp_head_after", 64'(out_tag), 64'd9);
    check("pp_busy", 64'(busy), 64'd1);
    drain("pp");
    check("pp_pops", 64'(n_pop - p0), 64'd3);

    // Reset with two ops in the pipe and one in the FIFO
    @(posedge clk); #1;
    out_ready = 1'b0;
    p0 = n_pop;
    for (int i = 0; i < 3; i++) send(op_a(60 + i), op_b(60 + i), 4'(12 + i), 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid_low", 64'(out_valid), 64'd0);
    check("mid_rst_busy_low", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 64'(busy), 64'd0);
    for (int c = 0; c < 5; c++) begin
      check("mid_rst_no_stale", 64'(out_valid), 64'd0);
      @(negedge clk);
    end
    check("mid_rst_pops", 64'(n_pop - p0), 64'd0);

    // Wrap-around with random back-pressure
    @(posedge clk); #1;
    p0 = n_pop;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) send(op_a(100 + i), op_b(100 + i), 4'(i), 1'(i % 3 == 0));
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    drain("wrap");
    check("wrap_pops", 64'(n_pop - p0), 64'd20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
